// File: rtl/map_pa_latch_if.sv
// Mapper-side view of the CPU/PPU buses and the PRG/CHR/CIRAM control lines.
// Bus semantics: no valid/ready handshake; a CPU write is the falling edge of
// cpu_m2 while cpu_rw=0, and the PPU strobes ppu_oe/ppu_we are active low.
interface map_pa_latch_if #(
  parameter int PRG_BITS  = 2,
  parameter int PAGE_BITS = 1,
  parameter int CHR_BITS  = 2
);
  logic [15:0]                        cpu_addr;
  logic [7:0]                         cpu_data;
  logic                               cpu_rw;
  logic                               cpu_m2;
  logic [13:0]                        ppu_addr;
  logic                               ppu_oe;
  logic                               ppu_we;
  logic                               prg_ce;
  logic                               prg_oe;
  logic [15+PRG_BITS-1:0]             prg_addr;
  logic                               chr_ce;
  logic                               chr_oe;
  logic                               chr_we;
  logic [12+CHR_BITS+PAGE_BITS-1:0]   chr_addr;
  logic                               ciram_a10;
  logic                               ciram_ce;

  modport master (
    output cpu_addr, cpu_data, cpu_rw, cpu_m2, ppu_addr, ppu_oe, ppu_we,
    input  prg_ce, prg_oe, prg_addr, chr_ce, chr_oe, chr_we, chr_addr,
           ciram_a10, ciram_ce
  );

  modport slave (
    input  cpu_addr, cpu_data, cpu_rw, cpu_m2, ppu_addr, ppu_oe, ppu_we,
    output prg_ce, prg_oe, prg_addr, chr_ce, chr_oe, chr_we, chr_addr,
           ciram_a10, ciram_ce
  );
endinterface

// File: rtl/map_pa_latch.sv
// PPU-address-latched CHR banking mapper: CPU-written PRG/CHR page/lock and a
// lower 4 KB CHR bank captured from nametable fetches behind a PA13 filter.
module map_pa_latch #(
  parameter int PRG_BITS  = 2,
  parameter int PAGE_BITS = 1,
  parameter int CHR_BITS  = 2,
  parameter int FILT_D    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  map_pa_latch_if.slave bus,
  input  logic          cfg_mir_v,
  input  logic          cfg_chr_ram,
  input  logic          sst_act,
  input  logic          sst_we,
  input  logic [7:0]    sst_addr,
  input  logic [7:0]    sst_dato,
  output logic [7:0]    sst_di
);
  localparam int CB = PRG_BITS + PAGE_BITS;

  logic [PRG_BITS-1:0]  prg_reg;
  logic [PAGE_BITS-1:0] chr_page;
  logic [CHR_BITS-1:0]  chr_bank;
  logic                 lock;
  logic [2:0]           m2_q;     // [0],[1] synchroniser, [2] previous sync output
  logic [FILT_D-1:0]    hist;

  logic m2_fall;
  logic cpu_wr;
  logic fire;
  logic latch_en;
  logic sst_wr;
  logic unused_data;

  assign m2_fall = m2_q[2] & ~m2_q[1];
  assign cpu_wr  = m2_fall & bus.cpu_addr[15] & ~bus.cpu_rw & ~sst_act;

  // One low sample followed by FILT_D-1 highs; a steady high cannot re-fire.
  assign fire     = ~hist[FILT_D-1] & (&hist[FILT_D-2:0]);
  assign latch_en = fire & ~bus.ppu_addr[12] & bus.ppu_oe & bus.ppu_we & ~lock & ~sst_act;
  assign sst_wr   = sst_act & sst_we;

  assign unused_data = ^{bus.cpu_data, sst_dato};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prg_reg  <= '0;
      chr_page <= '0;
      chr_bank <= '0;
      lock     <= 1'b0;
      m2_q     <= '0;
      hist     <= '0;
    end else begin
      m2_q <= {m2_q[1:0], bus.cpu_m2};
      hist <= {hist[FILT_D-2:0], bus.ppu_addr[13]};
      if (sst_wr) begin
        if (sst_addr == 8'd0) begin
          prg_reg  <= sst_dato[PRG_BITS-1:0];
          chr_page <= sst_dato[PRG_BITS +: PAGE_BITS];
          lock     <= sst_dato[7];
        end else if (sst_addr == 8'd1) begin
          chr_bank <= sst_dato[CHR_BITS-1:0];
        end
      end else begin
        if (cpu_wr) begin
          prg_reg  <= bus.cpu_data[PRG_BITS-1:0];
          chr_page <= bus.cpu_data[PRG_BITS +: PAGE_BITS];
          lock     <= bus.cpu_data[7];
        end
        if (latch_en) begin
          chr_bank <= bus.ppu_addr[8 +: CHR_BITS];
        end
      end
    end
  end

  always_comb begin
    sst_di = 8'hFF;
    case (sst_addr)
      8'd0: begin
        sst_di        = 8'h00;
        sst_di[7]     = lock;
        sst_di[CB-1:0] = {chr_page, prg_reg};
      end
      8'd1: begin
        sst_di                 = 8'h00;
        sst_di[CHR_BITS-1:0]   = chr_bank;
      end
      8'd127:  sst_di = 8'h60;
      default: sst_di = 8'hFF;
    endcase
  end

  assign bus.prg_ce   = bus.cpu_addr[15];
  assign bus.prg_oe   = bus.cpu_rw;
  assign bus.prg_addr = {prg_reg, bus.cpu_addr[14:0]};

  assign bus.chr_ce   = ~bus.ppu_addr[13];
  assign bus.ciram_ce = ~bus.ppu_addr[13];
  assign bus.chr_oe   = ~bus.ppu_oe;
  assign bus.chr_we   = cfg_chr_ram & ~bus.ppu_we & ~bus.ppu_addr[13];
  // Upper 4 KB always maps to the last bank of the selected page.
  assign bus.chr_addr = {chr_page,
                         bus.ppu_addr[12] ? {CHR_BITS{1'b1}} : chr_bank,
                         bus.ppu_addr[11:0]};

  assign bus.ciram_a10 = cfg_mir_v ? bus.ppu_addr[10] : bus.ppu_addr[11];
endmodule

// File: tb/tb_map_pa_latch.sv
// Directed testbench for map_pa_latch: CPU register writes, PA13-filtered CHR
// latching, save-state access, asynchronous reset and mirroring.
module tb_map_pa_latch;
  logic       clk;
  logic       rst_n;
  logic       cfg_mir_v;
  logic       cfg_chr_ram;
  logic       sst_act;
  logic       sst_we;
  logic [7:0] sst_addr;
  logic [7:0] sst_dato;
  logic [7:0] sst_di;

  int checks = 0;
  int errors = 0;

  map_pa_latch_if #(.PRG_BITS(2), .PAGE_BITS(1), .CHR_BITS(2)) bus ();

  map_pa_latch #(.PRG_BITS(2), .PAGE_BITS(1), .CHR_BITS(2), .FILT_D(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cfg_mir_v   (cfg_mir_v),
    .cfg_chr_ram (cfg_chr_ram),
    .sst_act     (sst_act),
    .sst_we      (sst_we),
    .sst_addr    (sst_addr),
    .sst_dato    (sst_dato),
    .sst_di      (sst_di)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ppu(input logic [13:0] a);
    bus.ppu_addr = a;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus.cpu_addr = a;
    bus.cpu_data = d;
    bus.cpu_rw   = rw;
    bus.cpu_m2   = 1'b1;
    tick(3);
    bus.cpu_m2 = 1'b0;
    tick(3);
    bus.cpu_rw   = 1'b1;
    bus.cpu_addr = 16'h0000;
  endtask

  task automatic fire_at(input logic [13:0] a);
    set_ppu(14'h0000);
    tick(5);
    set_ppu(a);
    tick(5);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL rst_regs0: got %0h expected 0", sst_di); end
    sst_addr = 8'd1; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL rst_bank: got %0h expected 0", sst_di); end
    bus.cpu_addr = 16'h8123; #1;
    checks++;
    if (bus.prg_addr !== 17'h00123) begin errors++; $display("FAIL rst_prg_addr: got %0h expected 123", bus.prg_addr); end
    checks++;
    if (bus.prg_ce !== 1'b1 || bus.prg_oe !== 1'b1) begin errors++; $display("FAIL rst_prg_ctl: got ce=%b oe=%b expected 1 1", bus.prg_ce, bus.prg_oe); end
    bus.cpu_addr = 16'h0000;
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_cpu_write;
    bus.cpu_addr = 16'h8000;
    bus.cpu_data = 8'h06;
    bus.cpu_rw   = 1'b0;
    bus.cpu_m2   = 1'b1;
    tick(3);
    bus.cpu_m2 = 1'b0;
    tick(2);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL wr_latency_early: got %0h expected 0", sst_di); end
    tick(1); #1;
    checks++;
    if (sst_di !== 8'h06) begin errors++; $display("FAIL wr_latency_edge3: got %0h expected 6", sst_di); end
    bus.cpu_rw = 1'b1; #1;
    checks++;
    if (bus.prg_addr !== 17'h10000) begin errors++; $display("FAIL prg_addr_8000: got %0h expected 10000", bus.prg_addr); end
    checks++;
    if (bus.prg_oe !== 1'b1) begin errors++; $display("FAIL prg_oe_read: got %b expected 1", bus.prg_oe); end
    bus.cpu_rw = 1'b0;
    bus.cpu_addr = 16'h7FFF; #1;
    checks++;
    if (bus.prg_ce !== 1'b0 || bus.prg_oe !== 1'b0 || bus.prg_addr !== 17'h17FFF) begin
      errors++; $display("FAIL prg_7fff: got ce=%b oe=%b addr=%0h expected 0 0 17fff", bus.prg_ce, bus.prg_oe, bus.prg_addr);
    end
    bus.cpu_rw = 1'b1;
    bus.cpu_addr = 16'h0000;
    tick(1);
    set_ppu(14'h0ABC); #1;
    checks++;
    if (bus.chr_addr !== 15'h4ABC) begin errors++; $display("FAIL chr_addr_lo: got %0h expected 4abc", bus.chr_addr); end
    set_ppu(14'h1ABC); #1;
    checks++;
    if (bus.chr_addr !== 15'h7ABC) begin errors++; $display("FAIL chr_addr_hi: got %0h expected 7abc", bus.chr_addr); end
    set_ppu(14'h0000);
    tick(1);
    cpu_cycle(16'h7FFF, 8'h01, 1'b0);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h06) begin errors++; $display("FAIL wr_below_8000: got %0h expected 6", sst_di); end
    cpu_cycle(16'h8000, 8'h03, 1'b1);
    #1;
    checks++;
    if (sst_di !== 8'h06) begin errors++; $display("FAIL read_no_write: got %0h expected 6", sst_di); end
  endtask

  task automatic test_latch;
    set_ppu(14'h0000);
    tick(5);
    set_ppu(14'h2300);
    tick(4);
    sst_addr = 8'd1; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL latch_edge4: got %0h expected 0", sst_di); end
    tick(1); #1;
    checks++;
    if (sst_di !== 8'h03) begin errors++; $display("FAIL latch_edge5: got %0h expected 3", sst_di); end
    set_ppu(14'h2100);
    tick(3); #1;
    checks++;
    if (sst_di !== 8'h03) begin errors++; $display("FAIL no_refire: got %0h expected 3", sst_di); end
    set_ppu(14'h0ABC);
    bus.ppu_oe = 1'b0; #1;
    checks++;
    if (bus.chr_addr !== 15'h7ABC) begin errors++; $display("FAIL chr_read_lo: got %0h expected 7abc", bus.chr_addr); end
    checks++;
    if (bus.chr_oe !== 1'b1 || bus.chr_ce !== 1'b1 || bus.ciram_ce !== 1'b1) begin
      errors++; $display("FAIL chr_strobes: got oe=%b ce=%b cce=%b expected 1 1 1", bus.chr_oe, bus.chr_ce, bus.ciram_ce);
    end
    bus.ppu_oe = 1'b1;
    tick(1);
    bus.ppu_we = 1'b0;
    cfg_chr_ram = 1'b0; #1;
    checks++;
    if (bus.chr_we !== 1'b0) begin errors++; $display("FAIL chr_we_rom: got %b expected 0", bus.chr_we); end
    cfg_chr_ram = 1'b1; #1;
    checks++;
    if (bus.chr_we !== 1'b1) begin errors++; $display("FAIL chr_we_ram: got %b expected 1", bus.chr_we); end
    set_ppu(14'h2ABC); #1;
    checks++;
    if (bus.chr_we !== 1'b0 || bus.chr_ce !== 1'b0 || bus.ciram_ce !== 1'b0) begin
      errors++; $display("FAIL chr_nt_sel: got we=%b ce=%b cce=%b expected 0 0 0", bus.chr_we, bus.chr_ce, bus.ciram_ce);
    end
    bus.ppu_we = 1'b1;
    cfg_chr_ram = 1'b0;
    set_ppu(14'h0000);
    tick(1);
  endtask

  task automatic test_glitch;
    set_ppu(14'h0000);
    tick(5);
    set_ppu(14'h2100);
    tick(3);
    set_ppu(14'h0000);
    tick(5);
    sst_addr = 8'd1; #1;
    checks++;
    if (sst_di !== 8'h03) begin errors++; $display("FAIL glitch_3: got %0h expected 3", sst_di); end
    set_ppu(14'h2100);
    tick(4);
    set_ppu(14'h0100);
    tick(1); #1;
    checks++;
    if (sst_di !== 8'h01) begin errors++; $display("FAIL pulse_4: got %0h expected 1", sst_di); end
  endtask

  task automatic test_qualify;
    sst_addr = 8'd1;
    fire_at(14'h3200); #1;
    checks++;
    if (sst_di !== 8'h01) begin errors++; $display("FAIL q_pa12: got %0h expected 1", sst_di); end
    bus.ppu_oe = 1'b0;
    fire_at(14'h2200);
    bus.ppu_oe = 1'b1; #1;
    checks++;
    if (sst_di !== 8'h01) begin errors++; $display("FAIL q_oe: got %0h expected 1", sst_di); end
    bus.ppu_we = 1'b0;
    fire_at(14'h2200);
    bus.ppu_we = 1'b1; #1;
    checks++;
    if (sst_di !== 8'h01) begin errors++; $display("FAIL q_we: got %0h expected 1", sst_di); end
    set_ppu(14'h0000);
    cpu_cycle(16'h8000, 8'h80, 1'b0);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h80) begin errors++; $display("FAIL lock_write: got %0h expected 80", sst_di); end
    sst_addr = 8'd1;
    fire_at(14'h2200); #1;
    checks++;
    if (sst_di !== 8'h01) begin errors++; $display("FAIL q_lock: got %0h expected 1", sst_di); end
    set_ppu(14'h0000);
    cpu_cycle(16'h8000, 8'h00, 1'b0);
    fire_at(14'h2200); #1;
    checks++;
    if (sst_di !== 8'h02) begin errors++; $display("FAIL q_unlock: got %0h expected 2", sst_di); end
  endtask

  task automatic test_back_to_back;
    set_ppu(14'h0000);
    tick(5);
    set_ppu(14'h2300);
    bus.cpu_addr = 16'h8000;
    bus.cpu_data = 8'h87;
    bus.cpu_rw   = 1'b0;
    bus.cpu_m2   = 1'b1;
    tick(2);
    bus.cpu_m2 = 1'b0;
    tick(2);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL same_pre_regs: got %0h expected 0", sst_di); end
    tick(1);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h87) begin errors++; $display("FAIL same_regs: got %0h expected 87", sst_di); end
    sst_addr = 8'd1; #1;
    checks++;
    if (sst_di !== 8'h03) begin errors++; $display("FAIL same_bank: got %0h expected 3", sst_di); end
    bus.cpu_rw = 1'b1;
    bus.cpu_addr = 16'h0000;
    set_ppu(14'h0000);
    tick(1);
  endtask

  task automatic test_save_state;
    sst_act  = 1'b1;
    sst_we   = 1'b1;
    sst_addr = 8'd0;
    sst_dato = 8'h85;
    tick(1);
    sst_addr = 8'd1;
    sst_dato = 8'h02;
    tick(1);
    sst_we = 1'b0;
    set_ppu(14'h0000);
    cpu_cycle(16'h8000, 8'h03, 1'b0);
    fire_at(14'h2300);
    set_ppu(14'h0000);
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h85) begin errors++; $display("FAIL sst_rd0: got %0h expected 85", sst_di); end
    sst_addr = 8'd1; #1;
    checks++;
    if (sst_di !== 8'h02) begin errors++; $display("FAIL sst_rd1: got %0h expected 2", sst_di); end
    sst_addr = 8'd127; #1;
    checks++;
    if (sst_di !== 8'h60) begin errors++; $display("FAIL sst_rd127: got %0h expected 60", sst_di); end
    sst_addr = 8'd5; #1;
    checks++;
    if (sst_di !== 8'hFF) begin errors++; $display("FAIL sst_rd5: got %0h expected ff", sst_di); end
    tick(1);
    sst_act  = 1'b0;
    sst_we   = 1'b1;
    sst_addr = 8'd0;
    sst_dato = 8'h00;
    tick(1);
    sst_we = 1'b0; #1;
    checks++;
    if (sst_di !== 8'h85) begin errors++; $display("FAIL sst_we_inactive: got %0h expected 85", sst_di); end
    bus.cpu_addr = 16'h8000; #1;
    checks++;
    if (bus.prg_addr !== 17'h08000) begin errors++; $display("FAIL sst_prg_addr: got %0h expected 8000", bus.prg_addr); end
    bus.cpu_addr = 16'h0000;
    tick(1);
  endtask

  task automatic test_reset_mid;
    set_ppu(14'h0000);
    tick(5);
    set_ppu(14'h2100);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0; #1;
    sst_addr = 8'd0; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL arst_regs0: got %0h expected 0", sst_di); end
    sst_addr = 8'd1; #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL arst_bank: got %0h expected 0", sst_di); end
    checks++;
    if (bus.prg_addr !== 17'h00000) begin errors++; $display("FAIL arst_prg_addr: got %0h expected 0", bus.prg_addr); end
    tick(2);
    rst_n = 1'b1;
    tick(3); #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL rel_high_no_fire: got %0h expected 0", sst_di); end
    set_ppu(14'h0000);
    tick(1);
    set_ppu(14'h2100);
    tick(4); #1;
    checks++;
    if (sst_di !== 8'h00) begin errors++; $display("FAIL rel_edge4: got %0h expected 0", sst_di); end
    tick(1); #1;
    checks++;
    if (sst_di !== 8'h01) begin errors++; $display("FAIL rel_fire: got %0h expected 1", sst_di); end
    set_ppu(14'h0000);
    tick(1);
  endtask

  task automatic test_mirroring;
    cfg_mir_v = 1'b1;
    set_ppu(14'h2400); #1;
    checks++;
    if (bus.ciram_a10 !== 1'b1) begin errors++; $display("FAIL mir_v_2400: got %b expected 1", bus.ciram_a10); end
    set_ppu(14'h2800); #1;
    checks++;
    if (bus.ciram_a10 !== 1'b0) begin errors++; $display("FAIL mir_v_2800: got %b expected 0", bus.ciram_a10); end
    tick(1);
    cfg_mir_v = 1'b0; #1;
    checks++;
    if (bus.ciram_a10 !== 1'b1) begin errors++; $display("FAIL mir_h_2800: got %b expected 1", bus.ciram_a10); end
    set_ppu(14'h2400); #1;
    checks++;
    if (bus.ciram_a10 !== 1'b0) begin errors++; $display("FAIL mir_h_2400: got %b expected 0", bus.ciram_a10); end
    set_ppu(14'h0000);
    tick(1);
  endtask

  initial begin
    rst_n        = 1'b0;
    cfg_mir_v    = 1'b0;
    cfg_chr_ram  = 1'b0;
    sst_act      = 1'b0;
    sst_we       = 1'b0;
    sst_addr     = 8'd0;
    sst_dato     = 8'd0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_data = 8'h00;
    bus.cpu_rw   = 1'b1;
    bus.cpu_m2   = 1'b0;
    bus.ppu_addr = 14'h0000;
    bus.ppu_oe   = 1'b1;
    bus.ppu_we   = 1'b1;

    test_reset();
    test_cpu_write();
    test_latch();
    test_glitch();
    test_qualify();
    test_back_to_back();
    test_save_state();
    test_reset_mid();
    test_mirroring();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
